// File: rtl/seg7_dec.sv
`default_nettype none
// ============================================================================
// Module   : seg7_dec
// Brief    : Samples a multiplexed active-low 7-segment bus, commits each
//            digit once stable, and hands off decoded frames via valid/ready.
// Revision : 1.0
// ============================================================================
module seg7_dec #(
    parameter int NDIG   = 6,
    parameter int STABLE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        seg_in,
    input  logic [NDIG-1:0]   dsel,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [4*NDIG-1:0] frame_val,
    output logic [NDIG-1:0]   frame_ok,
    output logic [NDIG-1:0]   frame_ovf,
    output logic              frame_err,
    output logic              frame_ovr
);

    localparam logic [6:0] C_MARKER = 7'b1001001;
    localparam logic [3:0] C_STABLE = 4'(STABLE);
    localparam logic [NDIG-1:0] C_ONE = {{(NDIG-1){1'b0}}, 1'b1};

    logic [6:0]        r_seg_q;
    logic [6:0]        r_seg_prev;
    logic [NDIG-1:0]   r_dsel_q;
    logic [NDIG-1:0]   r_dsel_prev;
    logic [3:0]        r_cnt;
    logic [NDIG-1:0]   r_seen;
    logic [4*NDIG-1:0] r_sh_val;
    logic [NDIG-1:0]   r_sh_ok;
    logic [NDIG-1:0]   r_sh_ovf;
    logic              r_sh_err;
    logic              r_valid;
    logic [4*NDIG-1:0] r_frame_val;
    logic [NDIG-1:0]   r_frame_ok;
    logic [NDIG-1:0]   r_frame_ovf;
    logic              r_frame_err;
    logic              r_ovr;

    logic              w_nonzero;
    logic              w_onehot;
    logic              w_multihot;
    logic              w_same;
    logic              w_commit;
    logic [3:0]        w_cnt_next;
    logic [3:0]        w_dec_val;
    logic              w_dec_ok;
    logic              w_dec_ovf;
    logic [NDIG-1:0]   w_seen_next;
    logic              w_transfer;
    logic              w_hs;
    logic              w_load;
    logic              w_drop;

    assign w_nonzero  = |r_dsel_q;
    assign w_onehot   = w_nonzero && ((r_dsel_q & (r_dsel_q - C_ONE)) == '0);
    assign w_multihot = w_nonzero && !w_onehot;
    assign w_same     = (r_seg_q == r_seg_prev) && (r_dsel_q == r_dsel_prev);
    // The counter only passes through STABLE-1 -> STABLE once per stable run.
    assign w_commit   = w_onehot && w_same && (r_cnt == C_STABLE - 4'd1);

    assign w_transfer = &r_seen;
    assign w_hs       = r_valid && frame_ready;
    assign w_load     = w_transfer && (!r_valid || w_hs);
    assign w_drop     = w_transfer && r_valid && !frame_ready;

    assign w_seen_next = (w_transfer ? '0 : r_seen) | (w_commit ? r_dsel_q : '0);

    always_comb begin
        w_cnt_next = r_cnt;
        if (!w_onehot) begin
            w_cnt_next = 4'd0;
        end else if (w_same) begin
            if (r_cnt != C_STABLE) begin
                w_cnt_next = r_cnt + 4'd1;
            end
        end else begin
            w_cnt_next = 4'd1;
        end
    end

    always_comb begin
        w_dec_val = 4'h0;
        w_dec_ok  = 1'b1;
        w_dec_ovf = 1'b0;
        case (r_seg_q)
            7'b1000000: w_dec_val = 4'h0;
            7'b1111001: w_dec_val = 4'h1;
            7'b0100100: w_dec_val = 4'h2;
            7'b0110000: w_dec_val = 4'h3;
            7'b0011001: w_dec_val = 4'h4;
            7'b0010010: w_dec_val = 4'h5;
            7'b0000010: w_dec_val = 4'h6;
            7'b1011000: w_dec_val = 4'h7;
            7'b0000000: w_dec_val = 4'h8;
            7'b0010000: w_dec_val = 4'h9;
            7'b0001000: w_dec_val = 4'hA;
            7'b0000011: w_dec_val = 4'hB;
            7'b1000110: w_dec_val = 4'hC;
            7'b0100001: w_dec_val = 4'hD;
            7'b0000110: w_dec_val = 4'hE;
            7'b0001110: w_dec_val = 4'hF;
            C_MARKER: begin
                w_dec_ok  = 1'b0;
                w_dec_ovf = 1'b1;
            end
            default: w_dec_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q     <= '0;
            r_seg_prev  <= '0;
            r_dsel_q    <= '0;
            r_dsel_prev <= '0;
            r_cnt       <= '0;
            r_seen      <= '0;
            r_sh_val    <= '0;
            r_sh_ok     <= '0;
            r_sh_ovf    <= '0;
            r_sh_err    <= 1'b0;
        end else begin
            r_seg_q     <= seg_in;
            r_seg_prev  <= r_seg_q;
            r_dsel_q    <= dsel;
            r_dsel_prev <= r_dsel_q;
            r_cnt       <= w_cnt_next;
            r_seen      <= w_seen_next;
            // A multi-hot sample in the transfer cycle belongs to the next frame.
            r_sh_err    <= (r_sh_err && !w_transfer) || w_multihot;
            for (int i = 0; i < NDIG; i++) begin
                if (w_commit && r_dsel_q[i]) begin
                    r_sh_val[4*i +: 4] <= w_dec_val;
                    r_sh_ok[i]         <= w_dec_ok;
                    r_sh_ovf[i]        <= w_dec_ovf;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_frame_val <= '0;
            r_frame_ok  <= '0;
            r_frame_ovf <= '0;
            r_frame_err <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid     <= 1'b1;
                r_frame_val <= r_sh_val;
                r_frame_ok  <= r_sh_ok;
                r_frame_ovf <= r_sh_ovf;
                r_frame_err <= r_sh_err;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
            if (w_hs) begin
                r_ovr <= 1'b0;
            end else if (w_drop) begin
                r_ovr <= 1'b1;
            end
        end
    end

    assign frame_valid = r_valid;
    assign frame_val   = r_frame_val;
    assign frame_ok    = r_frame_ok;
    assign frame_ovf   = r_frame_ovf;
    assign frame_err   = r_frame_err;
    assign frame_ovr   = r_ovr;

endmodule
`default_nettype wire
